// File: rtl/alu_result_checker.sv
// Scoreboard for the 4-bit ALU result interface: recomputes each beat's
// expected result, counts passes/failures and captures the first mismatching beat.
module alu_result_checker #(
    parameter int unsigned N_CHECKS = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [1:0]       control,
    input  logic [3:0]       op,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_flag,
    output logic [14:0]      first_fail
);

    localparam int unsigned ACC_W = 8;
    localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(N_CHECKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;
    logic   clear_run;
    logic   accept;

    logic [ACC_W-1:0] acc_cnt;

    // Compare stage: one registered beat awaiting its verdict
    logic       stg_valid;
    logic [3:0] stg_a;
    logic [3:0] stg_b;
    logic [1:0] stg_ctrl;
    logic [3:0] stg_op;
    logic       stg_cout;

    logic [4:0] sum5;
    logic [3:0] exp_op;
    logic       exp_cout;
    logic       beat_ok;

    assign accept = in_valid && in_ready;

    // Reference model of the ALU, evaluated on the staged beat
    always_comb begin
        sum5     = '0;
        exp_op   = '0;
        exp_cout = 1'b0;
        case (stg_ctrl)
            2'b00: begin
                sum5     = 5'(stg_a) + 5'(stg_b);
                exp_op   = sum5[3:0];
                exp_cout = sum5[4];
            end
            2'b01: begin
                exp_op   = stg_a - stg_b;
                exp_cout = (stg_a < stg_b);
            end
            2'b10: begin
                exp_op   = 4'(stg_a[1:0]) * 4'(stg_b[1:0]);
                exp_cout = 1'b0;
            end
            default: begin
                if (stg_b == 4'd0) begin
                    exp_op   = 4'b1111;
                    exp_cout = 1'b1;
                end else begin
                    exp_op   = stg_a / stg_b;
                    exp_cout = 1'b0;
                end
            end
        endcase
        beat_ok = (exp_op == stg_op) && (exp_cout == stg_cout);
    end

    // Next-state logic; DRAIN holds until the compare stage has emptied
    always_comb begin
        state_n   = state;
        clear_run = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_RUN;
                    clear_run = 1'b1;
                end
            end
            S_RUN: begin
                if (accept && (acc_cnt == LAST_IDX)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!stg_valid) begin
                    state_n = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and handshake/status registers, loaded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == S_RUN);
            busy     <= (state_n == S_RUN) || (state_n == S_DRAIN);
            done     <= (state_n == S_DONE);
        end
    end

    // Accepted-beat counter and compare stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt   <= '0;
            stg_valid <= 1'b0;
            stg_a     <= '0;
            stg_b     <= '0;
            stg_ctrl  <= '0;
            stg_op    <= '0;
            stg_cout  <= 1'b0;
        end else begin
            stg_valid <= accept;
            if (clear_run) begin
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + ACC_W'(1);
            end
            if (accept) begin
                stg_a    <= A;
                stg_b    <= B;
                stg_ctrl <= control;
                stg_op   <= op;
                stg_cout <= c_out;
            end
        end
    end

    // Result counters saturate; first_fail captures only the first mismatch of a run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_flag  <= 1'b0;
            first_fail <= '0;
        end else if (clear_run) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_flag  <= 1'b0;
            first_fail <= '0;
        end else if (stg_valid) begin
            if (beat_ok) begin
                if (pass_count != CNT_MAX) begin
                    pass_count <= pass_count + CNT_W'(1);
                end
            end else begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
                if (!fail_flag) begin
                    first_fail <= {stg_a, stg_b, stg_ctrl, stg_op, stg_cout};
                end
                fail_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed runs with hand-computed run totals,
// checked by per-instance monitors that pop expectations on each done pulse.
module tb_alu_result_checker;

    localparam int unsigned CNT_W_M = 8;
    localparam int unsigned CNT_W_S = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] ctrl;
        logic [3:0] op;
        logic       cout;
    } beat_t;

    typedef struct {
        int          pass;
        int          fail;
        int          flag;
        logic [14:0] ff;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_m;
    logic       start_s;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] control;
    logic [3:0] op;
    logic       c_out;

    logic               m_in_ready, m_busy, m_done, m_fail_flag;
    logic [CNT_W_M-1:0] m_pass_count, m_fail_count;
    logic [14:0]        m_first_fail;
    logic               s_in_ready, s_busy, s_done, s_fail_flag;
    logic [CNT_W_S-1:0] s_pass_count, s_fail_count;
    logic [14:0]        s_first_fail;

    alu_result_checker #(.N_CHECKS(8), .CNT_W(CNT_W_M)) u_main (
        .clk(clk), .rst(rst), .start(start_m), .in_valid(in_valid), .in_ready(m_in_ready),
        .A(a), .B(b), .control(control), .op(op), .c_out(c_out),
        .busy(m_busy), .done(m_done), .pass_count(m_pass_count), .fail_count(m_fail_count),
        .fail_flag(m_fail_flag), .first_fail(m_first_fail)
    );

    alu_result_checker #(.N_CHECKS(6), .CNT_W(CNT_W_S)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(a), .B(b), .control(control), .op(op), .c_out(c_out),
        .busy(s_busy), .done(s_done), .pass_count(s_pass_count), .fail_count(s_fail_count),
        .fail_flag(s_fail_flag), .first_fail(s_first_fail)
    );

    int checks = 0;
    int passed = 0;
    int m_done_cnt = 0;
    int s_done_cnt = 0;
    exp_t q_m[$];
    exp_t q_s[$];
    beat_t gold[8];
    beat_t fault[8];
    beat_t satv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic beat_t mk(input logic [3:0] ia, input logic [3:0] ib,
                                 input logic [1:0] ic, input logic [3:0] io, input logic ico);
        beat_t r;
        r.a = ia; r.b = ib; r.ctrl = ic; r.op = io; r.cout = ico;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int p, input int f, input int fl, input logic [14:0] ff);
        exp_t e;
        e.pass = p; e.fail = f; e.flag = fl; e.ff = ff;
        return e;
    endfunction

    // Present a beat; returns when it will be accepted at the next rising edge
    task automatic drive_beat(input beat_t bt, input bit sel_sat);
        int n = 0;
        @(negedge clk);
        {a, b, control, op, c_out} = bt;
        in_valid = 1'b1;
        while (!(sel_sat ? s_in_ready : m_in_ready)) begin
            n++;
            if (n > 50) begin
                check("beat_accept_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input bit sel_sat);
        @(negedge clk);
        in_valid = 1'b0;
        if (sel_sat) start_s = 1'b1;
        else start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        start_s = 1'b0;
        check("start_busy", sel_sat ? s_busy : m_busy, 1);
        check("start_in_ready", sel_sat ? s_in_ready : m_in_ready, 1);
    endtask

    task automatic wait_done(input bit sel_sat);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        start_m = 1'b0;
        start_s = 1'b0;
        while (!(sel_sat ? s_done : m_done)) begin
            n++;
            if (n > 20) begin
                check("done_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Monitor for the 8-beat instance
    bit m_prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (m_prev_done) check("m_done_width", m_done, 0);
        if (m_done) begin
            m_done_cnt++;
            if (q_m.size() == 0) begin
                check("m_unexpected_done", 0, 1);
            end else begin
                e = q_m.pop_front();
                check("m_pass_count", m_pass_count, e.pass);
                check("m_fail_count", m_fail_count, e.fail);
                check("m_fail_flag", m_fail_flag, e.flag);
                check("m_first_fail", m_first_fail, e.ff);
                check("m_busy_at_done", m_busy, 0);
            end
        end
        m_prev_done = m_done;
    end

    // Monitor for the saturating 2-bit-counter instance
    bit s_prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (s_prev_done) check("s_done_width", s_done, 0);
        if (s_done) begin
            s_done_cnt++;
            if (q_s.size() == 0) begin
                check("s_unexpected_done", 0, 1);
            end else begin
                e = q_s.pop_front();
                check("s_pass_count", s_pass_count, e.pass);
                check("s_fail_count", s_fail_count, e.fail);
                check("s_fail_flag", s_fail_flag, e.flag);
                check("s_first_fail", s_first_fail, e.ff);
            end
        end
        s_prev_done = s_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_neg;
        int done_neg;

        gold[0] = mk(4'd3,  4'd5, 2'b00, 4'b1000, 1'b0);
        gold[1] = mk(4'd15, 4'd1, 2'b00, 4'b0000, 1'b1);
        gold[2] = mk(4'd5,  4'd3, 2'b01, 4'b0010, 1'b0);
        gold[3] = mk(4'd3,  4'd5, 2'b01, 4'b1110, 1'b1);
        gold[4] = mk(4'b0001, 4'b0010, 2'b10, 4'b0010, 1'b0);
        gold[5] = mk(4'b0011, 4'b0010, 2'b10, 4'b0110, 1'b0);
        gold[6] = mk(4'd2,  4'd8, 2'b11, 4'b0000, 1'b0);
        gold[7] = mk(4'd1,  4'd0, 2'b11, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) fault[i] = gold[i];
        fault[2].op   = 4'b0011;
        fault[5].cout = 1'b1;
        for (int i = 0; i < 6; i++) begin
            satv[i] = gold[i];
            satv[i].op = gold[i].op ^ 4'b0001;
        end

        rst = 1'b1; start_m = 1'b0; start_s = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; control = '0; op = '0; c_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", m_in_ready, 0);
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_counts", {m_pass_count, m_fail_count}, 0);
        check("rst_flag_ff", {m_fail_flag, m_first_fail}, 0);

        // Reset mid-run after three beats; third beat still in the compare stage
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) drive_beat(gold[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_pass", m_pass_count, 2);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", m_in_ready, 0);
        check("midrst_busy", m_busy, 0);
        check("midrst_counts", {m_pass_count, m_fail_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_pass", m_pass_count, 0);
        check("postrst_idle", {m_busy, m_in_ready}, 0);

        // Golden back-to-back run
        q_m.push_back(mk_exp(8, 0, 0, 15'd0));
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) drive_beat(gold[i], 1'b0);
        wait_done(1'b0);

        // Injected faults on beats 3 and 6
        q_m.push_back(mk_exp(6, 2, 1, 15'b0101_0011_01_0011_0));
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) drive_beat(fault[i], 1'b0);
        wait_done(1'b0);
        check("idle_results_held", m_fail_count, 2);

        // start during RUN and during DRAIN is ignored
        q_m.push_back(mk_exp(8, 0, 0, 15'd0));
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) drive_beat(gold[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int i = 4; i < 8; i++) drive_beat(gold[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_state", {m_busy, m_in_ready}, 2'b10);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        wait_done(1'b0);
        check("idle_pass_held", m_pass_count, 8);

        // start after done clears counters; then alternating in_valid
        q_m.push_back(mk_exp(8, 0, 0, 15'd0));
        pulse_start(1'b0);
        check("start_clears", {m_pass_count, m_fail_count}, 0);
        acc = 0; acc_neg = -1; done_neg = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (m_done && done_neg < 0) done_neg = c;
            if (acc_neg >= 0 && c == acc_neg + 1) check("gap_ready_drop", m_in_ready, 0);
            if (c % 2 == 0) begin
                {a, b, control, op, c_out} = gold[(c / 2) % 8];
                in_valid = 1'b1;
                if (m_in_ready) begin
                    acc++;
                    if (acc == 8) acc_neg = c;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("gap_accepted", acc, 8);
        // accepted at the edge after negedge k; done rises two edges later, seen at negedge k+3
        check("gap_done_latency", done_neg - acc_neg, 3);

        // Saturation: 2-bit counters, six failing beats
        q_s.push_back(mk_exp(0, 3, 1, 15'b0011_0101_00_1001_0));
        pulse_start(1'b1);
        for (int i = 0; i < 6; i++) drive_beat(satv[i], 1'b1);
        wait_done(1'b1);
        repeat (3) @(negedge clk);

        check("m_queue_empty", q_m.size(), 0);
        check("s_queue_empty", q_s.size(), 0);
        check("m_done_pulses", m_done_cnt, 4);
        check("s_done_pulses", s_done_cnt, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
